uart_line_mux: RTL and testbench
================================

# uart_line_mux

Multi-channel simulation console aggregator. It collects byte streams from NUM_CH per-hart/per-device UART output ports and buffers each channel's bytes per line. It emits whole lines, never interleaved, on one ready/valid console stream tagged with the source channel. It sits between SimTop's UART outputs and the testbench console writer, replacing direct single-channel character printing in multi-core simulation.

## Interface
Parameters:
- NUM_CH, 4: number of input byte channels (1..16).
- DEPTH, 128: per-channel buffer entries, power of two ≥ 2.
- MAX_LINE, 64: forced line break length, 1 ≤ MAX_LINE ≤ DEPTH.
- CW, $clog2(NUM_CH) (min 1): channel-id width, derived.

Ports:
- clock  in  1  sole clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  NUM_CH  per-channel byte strobe; no backpressure.
- in_ch  in  8*NUM_CH  byte for channel c at [8c+7:8c].
- out_valid  out  1  console byte valid.
- out_ready  in  1  console sink accepts byte.
- out_ch  out  8  console byte.
- out_chan  out  CW  source channel of out_ch.
- out_last  out  1  out_ch ends the line.
- overflow  out  NUM_CH  sticky per-channel drop flag.
- drop_cnt  out  16*NUM_CH  per-channel dropped-byte count, saturating at 0xFFFF.

## Operation
- Each channel has a DEPTH-entry FIFO of {eol, byte}, plus the following counters:
  - occupancy, width log2(DEPTH)+1;
  - partial_len, bytes since the last eol;
  - eol_cnt, complete lines buffered.
- Push, when in_valid[c] is high:
  - If the FIFO is not full, store the byte.
  - eol = (byte == 8'h0A) || (partial_len == MAX_LINE-1).
  - On eol, partial_len clears to 0 and eol_cnt increments. Otherwise partial_len increments.
- Push to a full FIFO: drop the byte, set overflow[c], increment drop_cnt[c] (saturating). partial_len is unchanged.
- Full means occupancy == DEPTH after the same-cycle pop is taken into account. A push and a pop on the same channel in the same cycle are both performed.
- A channel is eligible when eol_cnt > 0.
- State machine:
  - IDLE: round-robin search starting at pointer rr.
    - If any channel is eligible, register grant = the first eligible channel at or after rr, then go to DRAIN.
    - Set rr = (grant+1) mod NUM_CH.
  - DRAIN:
    - out_valid = 1; out_ch/out_chan/out_last come from the granted FIFO head, with out_last = head.eol.
    - On out_valid && out_ready: pop the head.
    - If the popped entry had eol, decrement eol_cnt and return to IDLE.
- The granted channel cannot lose eligibility during DRAIN, because it holds at least one eol entry until that entry is popped.
- Net eol_cnt update on a cycle with both a push eol and a pop eol: unchanged.
- Partial lines, meaning bytes with no eol yet, are never emitted.
- Bytes arriving on a channel mid-drain are appended behind the line being drained. They are emitted only after that line completes.
- overflow and drop_cnt clear only on reset.

## Timing
- Reset (async assert, sync-safe deassert) sets:
  - state IDLE, rr = 0;
  - all occupancies, partial_len, eol_cnt = 0;
  - out_valid = 0, out_last = 0, out_ch = 0, out_chan = 0;
  - overflow = 0, drop_cnt = 0.
- Reset mid-drain discards all buffered data immediately.
- Latency:
  - eol byte pushed at edge t; eligibility visible after t.
  - Grant registered at edge t+1; out_valid high in the cycle after t+1.
  - With out_ready held high, an L-byte line occupies L consecutive output cycles.
  - One IDLE bubble cycle follows every line.
- out_ch, out_chan and out_last are stable while out_valid && !out_ready.
- out_valid never drops until the eol byte is accepted.
- Outputs are driven from registered state (state, grant) and RAM/FIFO head. There is no combinational path from in_valid/in_ch to out_*.

## Test plan
- Single line: ch0 pushes "hi\n" (68,69,0A) on consecutive cycles, out_ready = 1 → out_valid starts 2 cycles after 0A; out_ch 68,69,0A; out_chan 0; out_last only on 0A; then 1 idle cycle.
- Fairness:
  - Setup: ch1 and ch3 each complete "A\n" in the same cycle; ch1 then completes "B\n" again.
  - Required order: ch1 "A\n", ch3 "A\n", ch1 "B\n". No interleaving; out_chan matches every byte.
- Forced break: MAX_LINE = 4; ch2 pushes 6 bytes 31..36 with no newline → a line 31,32,33,34 is emitted with out_last on 34; 35,36 stay buffered until a 0A arrives.
- Overflow:
  - Stimulus: DEPTH = 8, out_ready = 0, ch0 pushes 10 bytes with no newline (MAX_LINE = 8).
  - Response: 8 bytes stored; overflow[0] = 1; drop_cnt[0] = 2.
  - Then raise out_ready: the line of 8 is emitted; overflow stays 1.
- Backpressure plus concurrent push: during a ch0 drain, toggle out_ready randomly while ch0 pushes a second line → outputs are held while stalled, the first line completes before the second, and there is no byte loss or duplication (scoreboard compare).
- Async reset: assert reset_n low mid-drain between clock edges → out_valid falls without a clock edge; after release, no stale bytes are emitted and all counters read 0.

Source files
------------

// File: rtl/uart_line_mux.sv
`default_nettype none
// ============================================================================
// uart_line_mux : buffers per-channel UART bytes into lines and emits whole
//                 lines, round-robin, on one channel-tagged console stream.
// Revision      : 1.0
// ============================================================================
module uart_line_mux #(
  parameter int NUM_CH   = 4,
  parameter int DEPTH    = 128,
  parameter int MAX_LINE = 64,
  parameter int CW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_CH-1:0]    in_valid,
  input  logic [8*NUM_CH-1:0]  in_ch,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_ch,
  output logic [CW-1:0]        out_chan,
  output logic                 out_last,
  output logic [NUM_CH-1:0]    overflow,
  output logic [16*NUM_CH-1:0] drop_cnt
);
  localparam int              PW         = $clog2(DEPTH);
  localparam int              OW         = PW + 1;
  localparam logic [OW-1:0]   C_DEPTH    = OW'(DEPTH);
  localparam logic [OW-1:0]   C_LAST_POS = OW'(MAX_LINE - 1);
  localparam logic [7:0]      C_NL       = 8'h0A;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_DRAIN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     grant_q, grant_d;
  logic [CW-1:0]     rr_q, rr_d;
  logic [CW-1:0]     cand;
  logic              found;
  logic              drain;
  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] pop;
  logic [8:0]        head [NUM_CH];
  logic [8:0]        head_sel;

  assign drain    = (state_q == S_DRAIN);
  assign head_sel = head[grant_q];

  // Outputs depend only on registered state/grant and the granted FIFO head.
  assign out_valid = drain;
  assign out_ch    = drain ? head_sel[7:0] : 8'h00;
  assign out_last  = drain & head_sel[8];
  assign out_chan  = drain ? grant_q : '0;

  always_comb begin
    pop = '0;
    if (drain && out_ready) pop[grant_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    found   = 1'b0;
    cand    = '0;
    case (state_q)
      S_IDLE: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (int'(rr_q) + i >= NUM_CH) cand = CW'(int'(rr_q) + i - NUM_CH);
          else                          cand = CW'(int'(rr_q) + i);
          if (!found && eligible[cand]) begin
            found   = 1'b1;
            grant_d = cand;
          end
        end
        if (found) begin
          state_d = S_DRAIN;
          rr_d    = (int'(grant_d) + 1 >= NUM_CH) ? '0 : CW'(int'(grant_d) + 1);
        end
      end
      S_DRAIN: begin
        if (out_ready && head_sel[8]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [8:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic [OW-1:0] part_q, part_d;
    logic [OW-1:0] eol_cnt_q, eol_cnt_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   drop_q, drop_d;
    logic [7:0]    byte_in;
    logic          full, push, eol_in, head_eol;

    assign byte_in  = in_ch[8*c +: 8];
    // Full is judged after this cycle's pop so a drained slot is reusable at once.
    assign full     = (occ_q - OW'(pop[c])) == C_DEPTH;
    assign push     = in_valid[c] & ~full;
    assign eol_in   = (byte_in == C_NL) || (part_q == C_LAST_POS);
    assign head[c]  = mem[rd_ptr_q];
    assign head_eol = mem[rd_ptr_q][8];

    assign eligible[c]          = (eol_cnt_q != '0);
    assign overflow[c]          = ovf_q;
    assign drop_cnt[16*c +: 16] = drop_q;

    always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      part_d    = part_q;
      ovf_d     = ovf_q;
      drop_d    = drop_q;
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        part_d   = eol_in ? '0 : part_q + OW'(1);
      end else if (in_valid[c]) begin
        ovf_d = 1'b1;
        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end
      if (pop[c]) rd_ptr_d = rd_ptr_q + PW'(1);
      occ_d     = occ_q + OW'(push) - OW'(pop[c]);
      eol_cnt_d = eol_cnt_q + OW'(push & eol_in) - OW'(pop[c] & head_eol);
    end

    always_ff @(posedge clock) begin
      if (push) mem[wr_ptr_q] <= {eol_in, byte_in};
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        wr_ptr_q  <= '0;
        rd_ptr_q  <= '0;
        occ_q     <= '0;
        part_q    <= '0;
        eol_cnt_q <= '0;
        ovf_q     <= 1'b0;
        drop_q    <= '0;
      end else begin
        wr_ptr_q  <= wr_ptr_d;
        rd_ptr_q  <= rd_ptr_d;
        occ_q     <= occ_d;
        part_q    <= part_d;
        eol_cnt_q <= eol_cnt_d;
        ovf_q     <= ovf_d;
        drop_q    <= drop_d;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_line_mux.sv
`default_nettype none
// ============================================================================
// tb_uart_line_mux : directed bench for uart_line_mux (4 ch, DEPTH 8, MAX_LINE 4)
// Revision         : 1.0
// ============================================================================
module tb_uart_line_mux;
  logic        clock;
  logic        reset_n;
  logic [3:0]  in_valid;
  logic [31:0] in_ch;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_ch;
  logic [1:0]  out_chan;
  logic        out_last;
  logic [3:0]  overflow;
  logic [63:0] drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [10:0] got_q[$];
  logic [10:0] exp_q[$];
  int          got_base = 0;

  logic        pv, pr;
  logic [10:0] pd;
  logic [7:0]  line2 [3];
  logic [7:0]  b;

  uart_line_mux #(
    .NUM_CH  (4),
    .DEPTH   (8),
    .MAX_LINE(4)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ch    (in_ch),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ch   (out_ch),
    .out_chan (out_chan),
    .out_last (out_last),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Accepted bytes as {chan, last, byte}; inputs only move just after posedge.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) got_q.push_back({out_chan, out_last, out_ch});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input logic [3:0] v, input logic [31:0] d);
    in_valid = v;
    in_ch    = d;
    tick();
    in_valid = '0;
    in_ch    = '0;
  endtask

  task automatic add(input logic [1:0] ch, input logic last, input logic [7:0] bt);
    exp_q.push_back({ch, last, bt});
  endtask

  task automatic wait_got(input int n, input int budget);
    for (int i = 0; i < budget && (got_q.size() - got_base) < n; i++) tick();
  endtask

  task automatic compare(input string tag);
    check({tag, "_len"}, 32'(got_q.size() - got_base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (got_base + i < got_q.size()) check(tag, 32'(got_q[got_base + i]), 32'(exp_q[i]));
    end
    got_base = got_q.size();
    exp_q.delete();
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = '0;
    in_ch     = '0;
    out_ready = 1'b1;
    line2[0]  = 8'h61;
    line2[1]  = 8'h62;
    line2[2]  = 8'h0A;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Reset state
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ch",    32'(out_ch),    32'd0);
    check("rst_chan",  32'(out_chan),  32'd0);
    check("rst_last",  32'(out_last),  32'd0);
    check("rst_ovf",   32'(overflow),  32'd0);
    check("rst_drop",  drop_cnt[31:0] | drop_cnt[63:32], 32'd0);

    // Single line with cycle-exact latency
    put(4'b0001, 32'h0000_0068);
    put(4'b0001, 32'h0000_0069);
    put(4'b0001, 32'h0000_000A);
    check("s1_wait_valid", 32'(out_valid), 32'd0);
    tick();
    check("s1_b0", {out_valid, out_chan, out_last, out_ch}, {20'd0, 1'b1, 2'd0, 1'b0, 8'h68});
    tick();
    check("s1_b1", {out_valid, out_chan, out_last, out_ch}, {20'd0, 1'b1, 2'd0, 1'b0, 8'h69});
    tick();
    check("s1_b2", {out_valid, out_chan, out_last, out_ch}, {20'd0, 1'b1, 2'd0, 1'b1, 8'h0A});
    tick();
    check("s1_bubble", 32'(out_valid), 32'd0);
    add(2'd0, 1'b0, 8'h68); add(2'd0, 1'b0, 8'h69); add(2'd0, 1'b1, 8'h0A);
    compare("s1_seq");

    // Fairness: ch1/ch3 finish together, ch1 finishes a second line
    put(4'b1010, 32'h4100_4100);
    put(4'b1010, 32'h0A00_0A00);
    put(4'b0010, 32'h0000_4200);
    put(4'b0010, 32'h0000_0A00);
    wait_got(6, 60);
    add(2'd1, 1'b0, 8'h41); add(2'd1, 1'b1, 8'h0A);
    add(2'd3, 1'b0, 8'h41); add(2'd3, 1'b1, 8'h0A);
    add(2'd1, 1'b0, 8'h42); add(2'd1, 1'b1, 8'h0A);
    compare("fair");

    // Forced break at MAX_LINE bytes; the remainder waits for a newline
    for (int i = 0; i < 6; i++) begin
      b = 8'h31 + 8'(i);
      put(4'b0100, {8'h00, b, 16'h0000});
    end
    wait_got(4, 40);
    repeat (15) tick();
    add(2'd2, 1'b0, 8'h31); add(2'd2, 1'b0, 8'h32);
    add(2'd2, 1'b0, 8'h33); add(2'd2, 1'b1, 8'h34);
    compare("brk1");
    put(4'b0100, 32'h000A_0000);
    wait_got(3, 40);
    add(2'd2, 1'b0, 8'h35); add(2'd2, 1'b0, 8'h36); add(2'd2, 1'b1, 8'h0A);
    compare("brk2");

    // Overflow with the sink stalled
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      b = 8'h50 + 8'(i);
      put(4'b0001, {24'h0, b});
    end
    check("ovf_flag",  32'(overflow),    32'h1);
    check("ovf_drop0", drop_cnt[15:0],   32'd2);
    check("ovf_dropx", drop_cnt[63:16] == 48'd0, 32'd1);
    out_ready = 1'b1;
    wait_got(8, 60);
    for (int i = 0; i < 8; i++) begin
      b = 8'h50 + 8'(i);
      add(2'd0, (i == 3) || (i == 7), b);
    end
    compare("ovf_lines");
    check("ovf_sticky", 32'(overflow), 32'h1);

    // Backpressure with a second line arriving mid-drain
    out_ready = 1'b0;
    put(4'b0001, 32'h0000_0078);
    put(4'b0001, 32'h0000_0079);
    put(4'b0001, 32'h0000_000A);
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    check("bp_grant", 32'(out_valid), 32'd1);
    for (int i = 0; i < 24; i++) begin
      if (i >= 2 && i <= 4) begin
        in_valid = 4'b0001;
        in_ch    = {24'h0, line2[i-2]};
      end
      out_ready = 1'($urandom_range(0, 1));
      pv = out_valid;
      pr = out_ready;
      pd = {out_chan, out_last, out_ch};
      tick();
      in_valid = '0;
      in_ch    = '0;
      if (pv && !pr) check("bp_hold", {out_valid, out_chan, out_last, out_ch}, {20'd0, 1'b1, pd});
    end
    out_ready = 1'b1;
    wait_got(6, 60);
    add(2'd0, 1'b0, 8'h78); add(2'd0, 1'b0, 8'h79); add(2'd0, 1'b1, 8'h0A);
    add(2'd0, 1'b0, 8'h61); add(2'd0, 1'b0, 8'h62); add(2'd0, 1'b1, 8'h0A);
    compare("bp_seq");

    // Asynchronous reset mid-drain, ch2 holding a partial line
    out_ready = 1'b0;
    put(4'b0110, 32'h005A_5100);
    put(4'b0010, 32'h0000_0A00);
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    check("ar_pre", {out_valid, out_chan, out_ch}, {21'd0, 1'b1, 2'd1, 8'h51});
    #3;
    reset_n = 1'b0;
    #1;
    check("ar_valid_drop", 32'(out_valid), 32'd0);
    check("ar_outs_zero",  {out_chan, out_last, out_ch}, 32'd0);
    tick();
    tick();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    repeat (10) tick();
    compare("ar_no_stale");
    check("ar_ovf",  32'(overflow), 32'd0);
    check("ar_drop", drop_cnt[15:0], 32'd0);
    put(4'b1010, 32'h4B00_4B00);
    put(4'b1110, 32'h0A0A_0A00);
    wait_got(5, 60);
    add(2'd1, 1'b0, 8'h4B); add(2'd1, 1'b1, 8'h0A);
    add(2'd2, 1'b1, 8'h0A);
    add(2'd3, 1'b0, 8'h4B); add(2'd3, 1'b1, 8'h0A);
    compare("ar_post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
